core_sequencer: RTL

- Multi-cycle fetch/decode/execute sequencer for the 9-bit-instruction core.
- Owns the PC and the instruction register (IR).
- Gates the write enables produced by the control decoder (register file, data memory), so that each instruction commits exactly once, in the correct cycle.
- Starts the multi-cycle multiplier and waits for it; reports completion to the top level.

---
 rtl/core_sequencer_if.sv | 31 +++
 rtl/core_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// Bus between the sequencer and the rest of the core: ROM fetch, branch/multiplier
// handshakes, commit strobes and status.
interface core_sequencer_if #(
  parameter int unsigned PCW  = 10,
  parameter int unsigned CNTW = 16
);
  logic            start;
  logic [8:0]      instr_in;
  logic            br_cond;
  logic [PCW-1:0]  br_target;
  logic            mul_done;
  logic [PCW-1:0]  prog_addr;
  logic [8:0]      ir;
  logic            rf_we_en;
  logic            mem_we_en;
  logic            mul_start;
  logic            busy;
  logic            done;
  logic            err;
  logic [CNTW-1:0] retired;

  modport master (
    input  start, instr_in, br_cond, br_target, mul_done,
    output prog_addr, ir, rf_we_en, mem_we_en, mul_start, busy, done, err, retired
  );

  modport slave (
    output start, instr_in, br_cond, br_target, mul_done,
    input  prog_addr, ir, rf_we_en, mem_we_en, mul_start, busy, done, err, retired
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 9-bit core: owns PC and IR,
// gates decoder write enables to one commit per instruction and babysits the multiplier.
module core_sequencer #(
  parameter int unsigned PCW     = 10,
  parameter int unsigned MUL_MAX = 8,
  parameter int unsigned CNTW    = 16
) (
  input logic              clk,
  input logic              reset,
  core_sequencer_if.master bus
);

  localparam int unsigned TW = (MUL_MAX > 1) ? $clog2(MUL_MAX) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StMulw, StWb, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsMul, ClsHalt
  } cls_e;

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] retired_q, retired_d;

  cls_e cls;
  logic retire;
  logic restart;
  logic rf_we;
  logic mem_we;
  logic mul_st;

  always_comb begin
    cls = ClsAlu;
    unique case (ir_q[8:6])
      3'b000: begin
        if (ir_q[5:4] == 2'b10)      cls = ClsLoad;
        else if (ir_q[5:4] == 2'b11) cls = ClsStore;
      end
      3'b001:  cls = ClsLoad;
      3'b010:  cls = ClsStore;
      3'b100:  cls = ClsBranch;
      3'b111: begin
        if (ir_q[5:4] == 2'b10)      cls = ClsMul;
        else if (ir_q[5:4] == 2'b11) cls = ClsHalt;
      end
      default: cls = ClsAlu;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    timer_d = timer_q;
    err_d   = err_q;
    retire  = 1'b0;
    restart = 1'b0;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    mul_st  = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          restart = 1'b1;
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ir_d    = bus.instr_in;
        state_d = StDecode;
      end
      StDecode: begin
        if (cls == ClsHalt) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (cls)
          ClsLoad: state_d = StMem;
          ClsMul: begin
            mul_st  = 1'b1;
            timer_d = '0;
            state_d = StMulw;
          end
          ClsBranch: begin
            pc_d    = bus.br_cond ? bus.br_target : pc_q + 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
          ClsStore: begin
            mem_we  = 1'b1;
            pc_d    = pc_q + 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: begin
            rf_we   = 1'b1;
            pc_d    = pc_q + 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMem: state_d = StWb;
      StMulw: begin
        // Completion is checked first so a done on the last allowed cycle still wins.
        if (bus.mul_done) begin
          state_d = StWb;
        end else if (timer_q == TW'(MUL_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_d    = pc_q + 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (restart) begin
      retired_d = '0;
    end else if (retire && (retired_q != {CNTW{1'b1}})) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= 9'h000;
      timer_q   <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.rf_we_en  = rf_we;
  assign bus.mem_we_en = mem_we;
  assign bus.mul_start = mul_st;
  assign bus.busy      = (state_q != StIdle) && (state_q != StHalt);
  assign bus.done      = (state_q == StHalt);
  assign bus.err       = err_q;
  assign bus.retired   = retired_q;

endmodule
